// File: rtl/dmem_lsu.sv
// Load/store unit between the single-cycle control unit and a word-organised data memory.
// Latency: 3 cycles for a zero-wait access (IDLE→BUSY→DONE); an access error completes in 2.
// Backpressure: stays in BUSY until mem_ready, stalling the PC; aborts after TIMEOUT cycles.
//
// Ports:
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   req_rd/req_wr     : load / store request from the control unit
//   req_addr          : byte address; req_wdata: right-justified store data
//   req_fun3          : instruction fun3 (access size and signedness)
//   rdata             : right-justified, unextended load data (held until next load completes)
//   stall             : holds PC/instruction while an access is outstanding
//   err_access        : one-cycle pulse for a misaligned or illegal request
//   err_timeout       : one-cycle pulse when memory never answered
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata : registered memory request
//   mem_ready/mem_rdata                      : memory completion and read word
module dmem_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_fun3,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        err_access,
  output logic        err_timeout,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int             CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    size_q;     // 00 byte, 01 half, 10 word
  logic [1:0]    addr_lo_q;  // byte lane of the outstanding access

  logic          req_any;
  logic [1:0]    size_d;
  logic          illegal;
  logic          misaligned;
  logic [3:0]    be_d;
  logic [31:0]   wdata_d;
  logic [31:0]   rd_shift_b;
  logic [31:0]   rd_shift_h;
  logic [31:0]   rdata_ext;

  // Request decode: size, legality, lane enables and replicated write data.
  always_comb begin
    req_any = req_rd | req_wr;
    size_d  = req_fun3[1:0];

    if (req_rd && req_wr) begin
      illegal = 1'b1;
    end else if (req_rd) begin
      illegal = !(req_fun3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end else begin
      illegal = !(req_fun3 inside {3'b000, 3'b001, 3'b010});
    end

    misaligned = ((size_d == 2'b01) && req_addr[0]) ||
                 ((size_d == 2'b10) && (req_addr[1:0] != 2'b00));

    case (size_d)
      2'b00: begin
        be_d    = 4'b0001 << req_addr[1:0];
        wdata_d = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_d    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{req_wdata[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = req_wdata;
      end
    endcase
  end

  // Read extraction uses the lane/size latched at request time, not the live inputs.
  always_comb begin
    rd_shift_b = mem_rdata >> {addr_lo_q, 3'b000};
    rd_shift_h = mem_rdata >> {addr_lo_q[1], 4'b0000};
    case (size_q)
      2'b00:   rdata_ext = {24'b0, rd_shift_b[7:0]};
      2'b01:   rdata_ext = {16'b0, rd_shift_h[15:0]};
      default: rdata_ext = mem_rdata;
    endcase
  end

  // Stall is the only combinational output; it must read 0 while reset is held.
  always_comb begin
    stall = rst_n && ((state_q == BUSY) || ((state_q == IDLE) && req_any));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      size_q      <= 2'b00;
      addr_lo_q   <= 2'b00;
      rdata       <= '0;
      err_access  <= 1'b0;
      err_timeout <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_be      <= '0;
      mem_wdata   <= '0;
    end else begin
      err_access  <= 1'b0;
      err_timeout <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_any) begin
            if (illegal || misaligned) begin
              // Rejected without touching memory; the error shows in DONE.
              err_access <= 1'b1;
              state_q    <= DONE;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= req_wr;
              mem_addr  <= req_addr[31:2];
              mem_be    <= be_d;
              mem_wdata <= req_wr ? wdata_d : 32'h0;
              size_q    <= size_d;
              addr_lo_q <= req_addr[1:0];
              cnt_q     <= '0;
              state_q   <= BUSY;
            end
          end
        end
        BUSY: begin
          if (mem_ready) begin
            if (!mem_we) begin
              rdata <= rdata_ext;
            end
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            cnt_q     <= '0;
            state_q   <= DONE;
          end else if (cnt_q == CNT_LAST) begin
            // TIMEOUT cycles of mem_req without a response: abandon the access.
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_be      <= '0;
            mem_wdata   <= '0;
            cnt_q       <= '0;
            err_timeout <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          // The retiring instruction is still on the request inputs; never restart here.
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_rd, req_wr;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_fun3;
  logic [31:0] rdata;
  logic        stall, err_access, err_timeout;
  logic        mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_lsu #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_rd     (req_rd),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_fun3   (req_fun3),
    .rdata      (rdata),
    .stall      (stall),
    .err_access (err_access),
    .err_timeout(err_timeout),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  fun3;
    logic [31:0] mrd;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rdat;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Starts and ends at the drive point (#1 after a rising edge); memory answers at once.
  task automatic run_vec(input vec_t v, input string tag);
    req_rd    = v.rd;
    req_wr    = v.wr;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_fun3  = v.fun3;
    mem_rdata = v.mrd;
    mem_ready = 1'b1;
    #1;
    chk({tag, "_stall0"}, 32'(stall), 32'd1);
    chk({tag, "_req0"}, 32'(mem_req), 32'd0);
    @(posedge clk); #2;
    if (!v.err) begin
      chk({tag, "_req1"}, 32'(mem_req), 32'd1);
      chk({tag, "_we"}, 32'(mem_we), 32'(v.we));
      chk({tag, "_addr"}, 32'(mem_addr), 32'(v.addr[31:2]));
      chk({tag, "_be"}, 32'(mem_be), 32'(v.be));
      chk({tag, "_wdata"}, mem_wdata, v.wd);
      chk({tag, "_stall1"}, 32'(stall), 32'd1);
      @(posedge clk); #2;
    end
    chk({tag, "_done_stall"}, 32'(stall), 32'd0);
    chk({tag, "_done_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_done_be"}, 32'(mem_be), 32'd0);
    chk({tag, "_err_access"}, 32'(err_access), 32'(v.err));
    chk({tag, "_rdata"}, rdata, v.rdat);
    req_rd = 1'b0;
    req_wr = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_idle_err"}, 32'(err_access), 32'd0);
  endtask

  initial begin
    int   stl, rq, bad;
    logic done;
    vec_t v;

    //        rd   wr   addr          wdata         f3      mem_rdata     be       we   wd            err  rdata
    vt[0]  = '{1'b1, 1'b0, 32'h40, 32'h0,        3'b010, 32'hDEADBEEF, 4'b1111, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF};
    vt[1]  = '{1'b1, 1'b0, 32'h43, 32'h0,        3'b000, 32'h80112233, 4'b1000, 1'b0, 32'h0,        1'b0, 32'h00000080};
    vt[2]  = '{1'b1, 1'b0, 32'h42, 32'h0,        3'b001, 32'h80112233, 4'b1100, 1'b0, 32'h0,        1'b0, 32'h00008011};
    vt[3]  = '{1'b1, 1'b0, 32'h41, 32'h0,        3'b100, 32'h80112233, 4'b0010, 1'b0, 32'h0,        1'b0, 32'h00000022};
    vt[4]  = '{1'b1, 1'b0, 32'h40, 32'h0,        3'b101, 32'h80112233, 4'b0011, 1'b0, 32'h0,        1'b0, 32'h00002233};
    vt[5]  = '{1'b0, 1'b1, 32'h41, 32'h000000A5, 3'b000, 32'h0,        4'b0010, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h00002233};
    vt[6]  = '{1'b0, 1'b1, 32'h44, 32'hCAFEF00D, 3'b010, 32'h0,        4'b1111, 1'b1, 32'hCAFEF00D, 1'b0, 32'h00002233};
    vt[7]  = '{1'b0, 1'b1, 32'h40, 32'hFFFF5678, 3'b001, 32'h0,        4'b0011, 1'b1, 32'h56785678, 1'b0, 32'h00002233};
    vt[8]  = '{1'b1, 1'b0, 32'h42, 32'h0,        3'b010, 32'h12345678, 4'b0000, 1'b0, 32'h0,        1'b1, 32'h00002233};
    vt[9]  = '{1'b0, 1'b1, 32'h41, 32'h1234,     3'b001, 32'h0,        4'b0000, 1'b0, 32'h0,        1'b1, 32'h00002233};
    vt[10] = '{1'b1, 1'b0, 32'h40, 32'h0,        3'b011, 32'h12345678, 4'b0000, 1'b0, 32'h0,        1'b1, 32'h00002233};
    vt[11] = '{1'b1, 1'b1, 32'h40, 32'h0,        3'b010, 32'h12345678, 4'b0000, 1'b0, 32'h0,        1'b1, 32'h00002233};
    vt[12] = '{1'b0, 1'b1, 32'h40, 32'h0,        3'b100, 32'h0,        4'b0000, 1'b0, 32'h0,        1'b1, 32'h00002233};
    vt[13] = '{1'b1, 1'b0, 32'h40, 32'h0,        3'b000, 32'hAABBCC7F, 4'b0001, 1'b0, 32'h0,        1'b0, 32'h0000007F};

    // Reset: outputs cleared, stall suppressed even with a request present.
    rst_n = 1'b0;
    req_rd = 1'b1; req_wr = 1'b0; req_addr = 32'h40; req_wdata = 32'h0;
    req_fun3 = 3'b010; mem_ready = 1'b0; mem_rdata = 32'h0;
    #12;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_errs", {30'b0, err_access, err_timeout}, 32'h0);
    chk("rst_be", 32'(mem_be), 32'd0);
    req_rd = 1'b0;
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_stall", 32'(stall), 32'd0);

    for (int i = 0; i < 14; i++) begin
      run_vec(vt[i], $sformatf("v%0d", i));
    end

    // SH with memory ready only on the 4th BUSY cycle.
    req_wr = 1'b1; req_addr = 32'h42; req_wdata = 32'h1234; req_fun3 = 3'b001;
    mem_ready = 1'b0;
    stl = 0; rq = 0; bad = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (stall) stl++;
      if (mem_req) begin
        rq++;
        if (mem_be !== 4'b1100 || mem_wdata !== 32'h12341234 || mem_we !== 1'b1) bad++;
        if (rq == 4) mem_ready = 1'b1;
      end
      if (!stall) done = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("sh_wait_bound", 32'(done), 32'd1);
    chk("sh_wait_stall_cycles", 32'(stl), 32'd5);
    chk("sh_wait_req_cycles", 32'(rq), 32'd4);
    chk("sh_wait_stable", 32'(bad), 32'd0);
    chk("sh_wait_no_timeout", 32'(err_timeout), 32'd0);
    req_wr = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;

    // LW that never gets mem_ready: abort after 16 request cycles.
    req_rd = 1'b1; req_addr = 32'h80; req_fun3 = 3'b010; mem_rdata = 32'h55555555;
    stl = 0; rq = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (stall) stl++;
      if (mem_req) rq++;
      if (!stall) done = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("to_bound", 32'(done), 32'd1);
    chk("to_req_cycles", 32'(rq), 32'd16);
    chk("to_stall_cycles", 32'(stl), 32'd17);
    chk("to_err_timeout", 32'(err_timeout), 32'd1);
    chk("to_err_access", 32'(err_access), 32'd0);
    chk("to_req_dropped", 32'(mem_req), 32'd0);
    chk("to_rdata_kept", rdata, 32'h0000007F);
    req_rd = 1'b0;
    @(posedge clk); #1;
    chk("to_pulse_end", 32'(err_timeout), 32'd0);

    // Reset pulsed while BUSY: mem_req must fall without waiting for a clock edge.
    req_rd = 1'b1; req_addr = 32'h40; req_fun3 = 3'b010; mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
    end
    #1;
    chk("rb_req_before", 32'(mem_req), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rb_req_async", 32'(mem_req), 32'd0);
    chk("rb_stall", 32'(stall), 32'd0);
    chk("rb_rdata", rdata, 32'h0);
    req_rd = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rb_idle_stall", 32'(stall), 32'd0);
    chk("rb_idle_req", 32'(mem_req), 32'd0);
    v = '{1'b1, 1'b0, 32'h40, 32'h0, 3'b010, 32'h11223344, 4'b1111, 1'b0, 32'h0, 1'b0, 32'h11223344};
    run_vec(v, "rb_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
